// File: rtl/traffic_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_timer
// Description : Dwell-time controller placed ahead of a RED/GREEN/YELLOW
//               sequencer. Divides clk to a 1 s tick, times each lamp phase
//               against its programmed duration and issues a one-cycle
//               advance pulse. Latches pedestrian requests, shortens GREEN
//               once a minimum green has elapsed and grants WALK for the
//               following RED phase. Flags illegal lamp patterns, illegal
//               phase order and a sequencer that ignores advance.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_timer #(
    parameter int CLK_DIV       = 50_000_000,
    parameter int RED_SEC       = 10,
    parameter int GREEN_SEC     = 8,
    parameter int YELLOW_SEC    = 3,
    parameter int MIN_GREEN_SEC = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             ped_req,
    input  logic             red_i,
    input  logic             yellow_i,
    input  logic             green_i,
    output logic             advance,
    output logic [CNT_W-1:0] remaining,
    output logic             ped_pending,
    output logic             ped_walk,
    output logic             phase_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_ps_w       = $clog2(CLK_DIV);
    localparam logic [c_ps_w-1:0] c_ps_max    = c_ps_w'(CLK_DIV - 1);
    localparam logic [c_ps_w-1:0] c_ps_one    = c_ps_w'(1);
    localparam logic [CNT_W-1:0] c_red_dur    = CNT_W'(RED_SEC);
    localparam logic [CNT_W-1:0] c_green_dur  = CNT_W'(GREEN_SEC);
    localparam logic [CNT_W-1:0] c_yellow_dur = CNT_W'(YELLOW_SEC);
    localparam logic [CNT_W-1:0] c_rem_one    = CNT_W'(1);
    // GREEN may be cut once (GREEN_SEC - remaining + 1) >= MIN_GREEN_SEC,
    // i.e. once remaining <= GREEN_SEC + 1 - MIN_GREEN_SEC. Comparing against
    // this bound avoids any subtraction underflow on remaining.
    localparam logic [CNT_W:0]   c_cut_max    = (CNT_W+1)'(int'(c_green_dur) + 1 - MIN_GREEN_SEC);
    // WAIT_PH gives up at the end of the third cycle after advance.
    localparam logic [1:0]       c_wait_last  = 2'd3;
    localparam logic [1:0]       c_wait_one   = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_WAIT_PH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    phase_t              r_prev_phase;
    logic [c_ps_w-1:0]   r_prescaler;
    logic [1:0]          r_wait_cnt;
    logic                r_advance;
    logic [CNT_W-1:0]    r_remaining;
    logic                r_ped_pending;
    logic                r_ped_walk;
    logic                r_phase_err;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    phase_t              w_phase;
    logic                w_lamp_bad;
    phase_t              w_successor;
    logic [CNT_W-1:0]    w_duration;
    logic                w_entry;
    logic                w_illegal;
    logic                w_tick;
    logic                w_expire;
    logic                w_green_cut;
    logic                w_wait_done;

    // Decode the sequencer lamps; anything but a single lamp is an error and
    // is treated as RED so the intersection fails towards stop.
    always_comb begin
        w_lamp_bad = 1'b0;
        w_phase    = PH_RED;
        case ({red_i, yellow_i, green_i})
            3'b100:  w_phase = PH_RED;
            3'b010:  w_phase = PH_YELLOW;
            3'b001:  w_phase = PH_GREEN;
            default: begin
                w_phase    = PH_RED;
                w_lamp_bad = 1'b1;
            end
        endcase
    end

    // Legal next phase after the one currently being timed.
    always_comb begin
        w_successor = PH_NONE;
        case (r_prev_phase)
            PH_RED:    w_successor = PH_GREEN;
            PH_GREEN:  w_successor = PH_YELLOW;
            PH_YELLOW: w_successor = PH_RED;
            default:   w_successor = PH_NONE;
        endcase
    end

    // Programmed dwell of the phase currently shown by the lamps.
    always_comb begin
        w_duration = c_red_dur;
        case (w_phase)
            PH_GREEN:  w_duration = c_green_dur;
            PH_YELLOW: w_duration = c_yellow_dur;
            default:   w_duration = c_red_dur;
        endcase
    end

    // A lamp change is only acted upon while enabled; disabling takes priority.
    assign w_entry     = enable && (w_phase != r_prev_phase);
    // The very first entry after reset has no predecessor and is never illegal.
    assign w_illegal   = (r_prev_phase != PH_NONE) && (w_phase != w_successor);
    assign w_tick      = (r_state == ST_COUNT) && (r_prescaler == c_ps_max);
    // <= 1 rather than == 1 keeps remaining saturating at 0 when resuming
    // from a frozen WAIT_PH with nothing left to count.
    assign w_expire    = (r_remaining <= c_rem_one);
    assign w_green_cut = (w_phase == PH_GREEN) && r_ped_pending &&
                         ({1'b0, r_remaining} <= c_cut_max);
    assign w_wait_done = (r_wait_cnt == c_wait_last);

    // Controller: prescaler, phase timing FSM, pedestrian latch and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_prev_phase  <= PH_NONE;
            r_prescaler   <= '0;
            r_wait_cnt    <= '0;
            r_advance     <= 1'b0;
            r_remaining   <= '0;
            r_ped_pending <= 1'b0;
            r_ped_walk    <= 1'b0;
            r_phase_err   <= 1'b0;
        end else begin
            // advance is a single-cycle pulse unless re-issued below.
            r_advance <= 1'b0;

            // Button presses are latched in every state, even while frozen.
            if (ped_req) begin
                r_ped_pending <= 1'b1;
            end

            if (enable && w_lamp_bad) begin
                r_phase_err <= 1'b1;
            end

            if (!enable) begin
                // Freeze: remaining is held, the partial second is discarded.
                r_state     <= ST_IDLE;
                r_prescaler <= '0;
                r_wait_cnt  <= '0;
            end else if (w_entry) begin
                // New phase shown by the sequencer: start timing it afresh.
                r_state      <= ST_COUNT;
                r_remaining  <= w_duration;
                r_prescaler  <= '0;
                r_wait_cnt   <= '0;
                r_prev_phase <= w_phase;
                if (w_illegal) begin
                    r_phase_err <= 1'b1;
                end
                // A pending request is served by this RED; leaving RED (any
                // entry into a non-RED phase) drops WALK. A press landing on
                // the entry edge itself is kept for the next RED.
                r_ped_walk    <= (w_phase == PH_RED) && r_ped_pending;
                r_ped_pending <= ped_req || (r_ped_pending && (w_phase != PH_RED));
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        // Resume the same phase with remaining untouched.
                        r_state     <= ST_COUNT;
                        r_prescaler <= '0;
                    end
                    ST_COUNT: begin
                        if (w_tick) begin
                            r_prescaler <= '0;
                            if (w_expire || w_green_cut) begin
                                r_advance   <= 1'b1;
                                r_remaining <= '0;
                                r_wait_cnt  <= '0;
                                r_state     <= ST_WAIT_PH;
                            end else begin
                                r_remaining <= r_remaining - c_rem_one;
                            end
                        end else begin
                            r_prescaler <= r_prescaler + c_ps_one;
                        end
                    end
                    ST_WAIT_PH: begin
                        if (w_wait_done) begin
                            // Sequencer ignored advance: flag it and retime
                            // the phase it is still showing.
                            r_phase_err <= 1'b1;
                            r_remaining <= w_duration;
                            r_prescaler <= '0;
                            r_state     <= ST_COUNT;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + c_wait_one;
                        end
                    end
                    default: begin
                        r_state     <= ST_IDLE;
                        r_prescaler <= '0;
                    end
                endcase
            end
        end
    end

    assign advance     = r_advance;
    assign remaining   = r_remaining;
    assign ped_pending = r_ped_pending;
    assign ped_walk    = r_ped_walk;
    assign phase_err   = r_phase_err;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_timer
// Description : Self-checking bench for traffic_phase_timer with an attached
//               lamp sequencer and a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_timer;

    localparam int CLK_DIV       = 4;
    localparam int RED_SEC       = 3;
    localparam int GREEN_SEC     = 4;
    localparam int YELLOW_SEC    = 2;
    localparam int MIN_GREEN_SEC = 2;
    localparam int CNT_W         = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             ped_req = 1'b0;
    logic [2:0]       lamps = 3'b100;   // {red, yellow, green}
    logic             advance;
    logic [CNT_W-1:0] remaining;
    logic             ped_pending;
    logic             ped_walk;
    logic             phase_err;

    int n_checks = 0;
    int n_errors = 0;

    // Sequencer: 1 = RED, 2 = GREEN, 3 = YELLOW
    int         seq_ph = 1;
    bit         seq_freeze = 1'b0;
    bit         lamp_ovr = 1'b0;
    logic [2:0] lamp_force = 3'b000;

    // Reference model state
    bit m_run, m_wait, m_adv, m_pend, m_walk, m_err;
    int m_age, m_frac, m_rem, m_prev;

    traffic_phase_timer #(
        .CLK_DIV(CLK_DIV), .RED_SEC(RED_SEC), .GREEN_SEC(GREEN_SEC),
        .YELLOW_SEC(YELLOW_SEC), .MIN_GREEN_SEC(MIN_GREEN_SEC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .ped_req(ped_req),
        .red_i(lamps[2]), .yellow_i(lamps[1]), .green_i(lamps[0]),
        .advance(advance), .remaining(remaining), .ped_pending(ped_pending),
        .ped_walk(ped_walk), .phase_err(phase_err)
    );

    always #5 clk = ~clk;

    function automatic int dur(input int ph);
        case (ph)
            1:       return RED_SEC;
            2:       return GREEN_SEC;
            3:       return YELLOW_SEC;
            default: return 0;
        endcase
    endfunction

    task automatic apply_lamps();
        if (lamp_ovr) lamps = lamp_force;
        else begin
            case (seq_ph)
                1:       lamps = 3'b100;
                2:       lamps = 3'b001;
                default: lamps = 3'b010;
            endcase
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_wait = 0; m_adv = 0; m_pend = 0; m_walk = 0; m_err = 0;
        m_age = 0; m_frac = 0; m_rem = 0; m_prev = 0;
    endtask

    // One clock of the specified behaviour, from the inputs present at the edge.
    task automatic model_update(input bit en, input bit ped, input logic [2:0] l);
        int ph;
        bit bad;
        bit old_pend;
        old_pend = m_pend;
        bad = 0;
        case (l)
            3'b100:  ph = 1;
            3'b001:  ph = 2;
            3'b010:  ph = 3;
            default: begin ph = 1; bad = 1; end
        endcase
        m_adv  = 0;
        m_pend = old_pend | ped;
        if (en && bad) m_err = 1;
        if (!en) begin
            m_run = 0; m_wait = 0; m_frac = 0;
        end else if (ph != m_prev) begin
            if (m_prev != 0 && ph != (m_prev % 3) + 1) m_err = 1;
            m_rem  = dur(ph); m_frac = 0; m_run = 1; m_wait = 0;
            m_walk = (ph == 1) && old_pend;
            m_pend = ped || (old_pend && ph != 1);
            m_prev = ph;
        end else if (!m_run) begin
            m_run = 1; m_frac = 0;
        end else if (m_wait) begin
            if (m_age == 3) begin
                m_err = 1; m_rem = dur(ph); m_frac = 0; m_wait = 0;
            end else m_age++;
        end else if (m_frac == CLK_DIV - 1) begin
            m_frac = 0;
            if (m_rem <= 1 || (ph == 2 && old_pend && (GREEN_SEC - m_rem + 1) >= MIN_GREEN_SEC)) begin
                m_adv = 1; m_rem = 0; m_wait = 1; m_age = 0;
            end else m_rem--;
        end else m_frac++;
    endtask

    task automatic step();
        bit old_adv;
        @(posedge clk);
        #1;
        if (!reset) begin
            old_adv = m_adv;
            model_update(enable, ped_req, lamps);
            if (old_adv && !seq_freeze) seq_ph = seq_ph % 3 + 1;
            apply_lamps();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ped_req = 1'b0; seq_ph = 1; seq_freeze = 0; lamp_ovr = 0;
        apply_lamps();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_adv(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (advance !== 1'b1 && n < 200);
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; model_reset();
        repeat (2) @(posedge clk);
        #1;
        if ({advance, remaining, ped_pending, ped_walk, phase_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_values got adv=%b rem=%0d pend=%b walk=%b err=%b exp all 0",
                     advance, remaining, ped_pending, ped_walk, phase_err);
        end
        n_checks++;
        reset = 1'b0;
        repeat (3) step();
        if (remaining !== 8'd0 || advance !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_disabled got rem=%0d adv=%b exp rem=0 adv=0", remaining, advance);
        end
        n_checks++;
    endtask

    task automatic test_first_red();
        logic [CNT_W-1:0] exp_rem;
        enable = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            step();
            exp_rem = (i <= 4) ? 8'd3 : (i <= 8) ? 8'd2 : (i <= 12) ? 8'd1 : 8'd0;
            if (remaining !== exp_rem) begin
                n_errors++;
                $display("FAIL first_red_rem cyc=%0d got=%0d exp=%0d", i, remaining, exp_rem);
            end
            n_checks++;
            if (advance !== (i == 13)) begin
                n_errors++;
                $display("FAIL first_red_adv cyc=%0d got=%b exp=%b", i, advance, (i == 13));
            end
            n_checks++;
        end
        step(); step();
        if (remaining !== 8'd4 || phase_err !== 1'b0) begin
            n_errors++;
            $display("FAIL green_load got rem=%0d err=%b exp rem=4 err=0", remaining, phase_err);
        end
        n_checks++;
    endtask

    task automatic test_free_run();
        int gaps[5] = '{16, 10, 14, 18, 10};
        int n;
        for (int k = 0; k < 5; k++) begin
            wait_adv(n);
            if (n != gaps[k]) begin
                n_errors++;
                $display("FAIL free_run_gap k=%0d got=%0d exp=%0d", k, n, gaps[k]);
            end
            n_checks++;
            if (ped_walk !== 1'b0 || phase_err !== 1'b0) begin
                n_errors++;
                $display("FAIL free_run_flags k=%0d got walk=%b err=%b exp 0 0", k, ped_walk, phase_err);
            end
            n_checks++;
        end
    endtask

    task automatic test_ped();
        int n;
        wait_adv(n);   // RED
        if (n != 14) begin
            n_errors++;
            $display("FAIL ped_red_gap got=%0d exp=14", n);
        end
        n_checks++;
        step();        // lamps now GREEN
        ped_req = 1'b1;
        step();        // GREEN entry edge
        ped_req = 1'b0;
        if (remaining !== 8'd4 || ped_pending !== 1'b1) begin
            n_errors++;
            $display("FAIL ped_latch got rem=%0d pend=%b exp rem=4 pend=1", remaining, ped_pending);
        end
        n_checks++;
        wait_adv(n);
        if (n != 8 || remaining !== 8'd0) begin
            n_errors++;
            $display("FAIL ped_green_cut got gap=%0d rem=%0d exp gap=8 rem=0", n, remaining);
        end
        n_checks++;
        wait_adv(n);   // YELLOW
        step(); step();
        if (ped_walk !== 1'b1 || ped_pending !== 1'b0 || remaining !== 8'd3) begin
            n_errors++;
            $display("FAIL ped_walk_grant got walk=%b pend=%b rem=%0d exp 1 0 3", ped_walk, ped_pending, remaining);
        end
        n_checks++;
        wait_adv(n);
        if (n != 12 || ped_walk !== 1'b1) begin
            n_errors++;
            $display("FAIL ped_walk_hold got gap=%0d walk=%b exp gap=12 walk=1", n, ped_walk);
        end
        n_checks++;
        step(); step();
        if (ped_walk !== 1'b0) begin
            n_errors++;
            $display("FAIL ped_walk_drop got=%b exp=0", ped_walk);
        end
        n_checks++;
    endtask

    task automatic test_enable_freeze();
        int n;
        n = 0;
        while (!(m_prev == 1 && m_rem == 2 && m_run && !m_wait) && n < 200) begin
            step();
            n++;
        end
        if (remaining !== 8'd2) begin
            n_errors++;
            $display("FAIL freeze_setup got rem=%0d exp=2", remaining);
        end
        n_checks++;
        enable = 1'b0;
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (remaining !== 8'd2 || advance !== 1'b0) begin
                n_errors++;
                $display("FAIL freeze_hold cyc=%0d got rem=%0d adv=%b exp rem=2 adv=0", i, remaining, advance);
            end
            n_checks++;
        end
        if (ped_pending !== 1'b1) begin
            n_errors++;
            $display("FAIL freeze_ped got=%b exp=1", ped_pending);
        end
        n_checks++;
        enable = 1'b1;
        step();
        wait_adv(n);
        if (n != 8) begin
            n_errors++;
            $display("FAIL resume_gap got=%0d exp=8", n);
        end
        n_checks++;
    endtask

    task automatic test_hold_timeout();
        int n;
        step(); step();  // GREEN entry
        seq_freeze = 1'b1;
        wait_adv(n);
        if (n != 8) begin
            n_errors++;
            $display("FAIL hold_cut_gap got=%0d exp=8", n);
        end
        n_checks++;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (phase_err !== (i == 4)) begin
                n_errors++;
                $display("FAIL hold_err cyc=%0d got=%b exp=%b", i, phase_err, (i == 4));
            end
            n_checks++;
        end
        if (remaining !== 8'd4) begin
            n_errors++;
            $display("FAIL hold_reload got=%0d exp=4", remaining);
        end
        n_checks++;
        seq_freeze = 1'b0;
        wait_adv(n);
        if (n != 8 || phase_err !== 1'b1) begin
            n_errors++;
            $display("FAIL hold_after got gap=%0d err=%b exp gap=8 err=1", n, phase_err);
        end
        n_checks++;
    endtask

    task automatic test_async_reset();
        repeat (3) step();
        #2;
        reset = 1'b1;
        #1;
        if ({advance, remaining, ped_pending, ped_walk, phase_err} !== '0) begin
            n_errors++;
            $display("FAIL async_reset got adv=%b rem=%0d pend=%b walk=%b err=%b exp all 0",
                     advance, remaining, ped_pending, ped_walk, phase_err);
        end
        n_checks++;
        do_reset();
    endtask

    task automatic test_bad_lamps();
        repeat (3) step();
        if (phase_err !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_pre got=%b exp=0", phase_err);
        end
        n_checks++;
        lamp_ovr = 1'b1; lamp_force = 3'b110; apply_lamps();
        step();
        lamp_ovr = 1'b0; apply_lamps();
        if (phase_err !== 1'b1 || remaining !== 8'd3) begin
            n_errors++;
            $display("FAIL bad_lamps got err=%b rem=%0d exp err=1 rem=3", phase_err, remaining);
        end
        n_checks++;
    endtask

    task automatic test_jump();
        int n;
        do_reset();
        enable = 1'b1;
        wait_adv(n);
        step(); step();
        if (phase_err !== 1'b0 || remaining !== 8'd4) begin
            n_errors++;
            $display("FAIL jump_pre got err=%b rem=%0d exp err=0 rem=4", phase_err, remaining);
        end
        n_checks++;
        seq_ph = 1; apply_lamps();
        step();
        if (phase_err !== 1'b1 || remaining !== 8'd3) begin
            n_errors++;
            $display("FAIL jump_err got err=%b rem=%0d exp err=1 rem=3", phase_err, remaining);
        end
        n_checks++;
    endtask

    task automatic test_random();
        logic [CNT_W-1:0] e_rem;
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            enable = 1'b1;
            for (int cyc = 0; cyc < 700; cyc++) begin
                enable  = ($urandom_range(0, 29) != 0);
                ped_req = ($urandom_range(0, 19) == 0);
                if (seg >= 2) begin
                    seq_freeze = ($urandom_range(0, 99) < 3);
                    lamp_ovr   = ($urandom_range(0, 499) == 0);
                    lamp_force = 3'($urandom_range(0, 7));
                    if ($urandom_range(0, 499) == 0) seq_ph = $urandom_range(1, 3);
                    apply_lamps();
                end
                step();
                e_rem = CNT_W'(m_rem);
                if (advance !== m_adv) begin
                    n_errors++;
                    $display("FAIL rnd_advance seg=%0d cyc=%0d got=%b exp=%b", seg, cyc, advance, m_adv);
                end
                n_checks++;
                if (remaining !== e_rem) begin
                    n_errors++;
                    $display("FAIL rnd_remaining seg=%0d cyc=%0d got=%0d exp=%0d", seg, cyc, remaining, e_rem);
                end
                n_checks++;
                if (ped_pending !== m_pend) begin
                    n_errors++;
                    $display("FAIL rnd_pending seg=%0d cyc=%0d got=%b exp=%b", seg, cyc, ped_pending, m_pend);
                end
                n_checks++;
                if (ped_walk !== m_walk) begin
                    n_errors++;
                    $display("FAIL rnd_walk seg=%0d cyc=%0d got=%b exp=%b", seg, cyc, ped_walk, m_walk);
                end
                n_checks++;
                if (phase_err !== m_err) begin
                    n_errors++;
                    $display("FAIL rnd_err seg=%0d cyc=%0d got=%b exp=%b", seg, cyc, phase_err, m_err);
                end
                n_checks++;
            end
            seq_freeze = 1'b0;
            lamp_ovr   = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        apply_lamps();
        test_reset();
        test_first_red();
        test_free_run();
        test_ped();
        test_enable_freeze();
        test_hold_timeout();
        test_async_reset();
        test_bad_lamps();
        test_jump();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
